// File: rtl/mac_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mac_seq_pkg
//  Brief    : Shared types and widths for the MAC job sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package mac_seq_pkg;

    localparam int IMG_W  = 72;
    localparam int WGT_W  = 36;
    localparam int EXPB_W = 5;
    localparam int OUT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic             last;
        logic [OUT_W-1:0] data;
    } res_entry_t;

endpackage
`default_nettype wire

// File: rtl/mac_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : mac_sequencer_if
//  Brief    : Job control, operand source, MAC and result-drain signals.
//  Revision : 1.0 - initial release
// ============================================================================
interface mac_sequencer_if #(
    parameter int CNT_W = 16
);
    import mac_seq_pkg::*;

    logic                start;
    logic [CNT_W-1:0]    num_ops;
    logic                busy;
    logic                done;
    logic                src_valid;
    logic                src_ready;
    logic [IMG_W-1:0]    src_image;
    logic [WGT_W-1:0]    src_weight;
    logic [EXPB_W-1:0]   src_exp_bias;
    logic [IMG_W-1:0]    mac_image;
    logic [WGT_W-1:0]    mac_weight;
    logic [EXPB_W-1:0]   mac_exp_bias;
    logic [OUT_W-1:0]    mac_out;
    logic                res_valid;
    logic                res_ready;
    logic [OUT_W-1:0]    res_data;
    logic                res_last;

    modport master (
        input  start, num_ops, src_valid, src_image, src_weight, src_exp_bias,
               mac_out, res_ready,
        output busy, done, src_ready, mac_image, mac_weight, mac_exp_bias,
               res_valid, res_data, res_last
    );

    modport slave (
        output start, num_ops, src_valid, src_image, src_weight, src_exp_bias,
               mac_out, res_ready,
        input  busy, done, src_ready, mac_image, mac_weight, mac_exp_bias,
               res_valid, res_data, res_last
    );

endinterface
`default_nettype wire

// File: rtl/mac_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : mac_result_fifo
//  Brief    : First-word fall-through synchronous FIFO for MAC results.
//  Revision : 1.0 - initial release
// ============================================================================
module mac_result_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 17
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     i_push,
    input  wire logic [WIDTH-1:0]         i_push_data,
    input  wire logic                     i_pop,
    output logic      [WIDTH-1:0]         o_head,
    output logic                          o_full,
    output logic                          o_empty,
    output logic      [$clog2(DEPTH):0]   o_count
);

    localparam int              AW      = $clog2(DEPTH);
    localparam logic [AW:0]     C_DEPTH = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == C_DEPTH);
    assign o_count = r_count;
    assign w_pop   = i_pop & ~o_empty;
    // A full FIFO may still accept a word when the head leaves on the same edge.
    assign w_push  = i_push & (~o_full | w_pop);
    assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mac_sequencer
//  Brief    : Issues job beats into a free-running MAC, captures results
//             into a credit-protected FWFT FIFO and drains them downstream.
//  Revision : 1.0 - initial release
// ============================================================================
module mac_sequencer
    import mac_seq_pkg::*;
#(
    parameter int MAC_LAT    = 5,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mac_sequencer_if.master    bus
);

    localparam int               IFL_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [IFL_W-1:0] C_CREDITS = IFL_W'(FIFO_DEPTH);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_num_ops;
    logic [CNT_W-1:0]   r_issued;
    logic [IFL_W-1:0]   r_inflight;
    logic [MAC_LAT:0]   r_trk;
    logic [MAC_LAT:0]   r_trk_last;
    logic [IMG_W-1:0]   r_mac_image;
    logic [WGT_W-1:0]   r_mac_weight;
    logic [EXPB_W-1:0]  r_mac_exp_bias;
    logic               w_src_ready;
    logic               w_issue;
    logic               w_last_beat;
    logic               w_accept;
    logic               w_pop;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [IFL_W-1:0]   w_fifo_count;
    res_entry_t         w_push_entry;
    res_entry_t         w_head;

    // Credits count tracker beats plus FIFO occupancy, so capture never overflows.
    assign w_src_ready = (r_state == ST_RUN) && (r_issued < r_num_ops)
                         && (r_inflight < C_CREDITS);
    assign w_issue     = bus.src_valid & w_src_ready;
    assign w_last_beat = ((r_issued + CNT_W'(1)) == r_num_ops);
    assign w_accept    = (r_state == ST_IDLE) & bus.start;
    assign w_pop       = ~w_fifo_empty & bus.res_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (bus.start) w_state_nxt = (bus.num_ops != '0) ? ST_RUN : ST_DONE;
            ST_RUN:   if (w_issue && w_last_beat) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (r_inflight == '0) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_num_ops      <= '0;
            r_issued       <= '0;
            r_inflight     <= '0;
            r_trk          <= '0;
            r_trk_last     <= '0;
            r_mac_image    <= '0;
            r_mac_weight   <= '0;
            r_mac_exp_bias <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_num_ops <= bus.num_ops;
                r_issued  <= '0;
            end else if (w_issue) begin
                r_issued  <= r_issued + CNT_W'(1);
            end
            case ({w_issue, w_pop})
                2'b10:   r_inflight <= r_inflight + IFL_W'(1);
                2'b01:   r_inflight <= r_inflight - IFL_W'(1);
                default: r_inflight <= r_inflight;
            endcase
            r_trk          <= {r_trk[MAC_LAT-1:0], w_issue};
            r_trk_last     <= {r_trk_last[MAC_LAT-1:0], w_issue & w_last_beat};
            r_mac_image    <= w_issue ? bus.src_image    : '0;
            r_mac_weight   <= w_issue ? bus.src_weight   : '0;
            r_mac_exp_bias <= w_issue ? bus.src_exp_bias : '0;
        end
    end

    assign w_push_entry = '{last: r_trk_last[MAC_LAT], data: bus.mac_out};

    mac_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(res_entry_t))
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (r_trk[MAC_LAT]),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(r_trk[MAC_LAT] && w_fifo_full && !w_pop));
            assert (w_fifo_count <= r_inflight);
        end
    end

    assign bus.busy         = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign bus.done         = (r_state == ST_DONE);
    assign bus.src_ready    = w_src_ready;
    assign bus.mac_image    = r_mac_image;
    assign bus.mac_weight   = r_mac_weight;
    assign bus.mac_exp_bias = r_mac_exp_bias;
    assign bus.res_valid    = ~w_fifo_empty;
    assign bus.res_data     = w_head.data;
    assign bus.res_last     = w_head.last;

endmodule
`default_nettype wire

// File: tb/tb_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mac_sequencer
//  Brief    : Randomised self-checking bench with a job-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mac_sequencer;
    import mac_seq_pkg::*;

    localparam int MAC_LAT = 5;
    localparam int DEPTH   = 8;
    localparam int LIMIT   = 3000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mac_sequencer_if #(.CNT_W(16)) bus ();

    mac_sequencer #(
        .MAC_LAT    (MAC_LAT),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] data;
        logic        last;
        int          t;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    exp_t        q[$];
    logic [15:0] mac_hist[$];
    int          cyc = 0;
    int          issued_m = 0, popped_m = 0, nops_m = 0;
    bit          in_job = 0;
    int          done_tmr = 0;
    int          p_valid = 100, p_ready = 100;
    bit          start_req = 0;
    int          start_n = 0;
    int          hs_seen = 0;
    logic [71:0] exp_img = '0;
    logic [35:0] exp_wgt = '0;
    logic [4:0]  exp_eb  = '0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Behavioural MAC: nine lane products plus exponent bias, offset so idle cycles are non-zero.
    function automatic logic [15:0] mac_fn(input logic [71:0] img, input logic [35:0] wgt,
                                           input logic [4:0] eb);
        logic [15:0] acc;
        acc = 16'h1234 + 16'(eb);
        for (int i = 0; i < 9; i++) acc = acc + 16'(img[i*8 +: 8]) * 16'(wgt[i*4 +: 4]);
        return acc;
    endfunction

    task automatic step();
        bit          exp_ready, exp_valid, hs;
        logic [95:0] rnd;
        @(negedge clk);
        cyc++;
        if (done_tmr > 0) done_tmr--;
        if (done_tmr == 1) in_job = 0;

        check_val("mac_image", bus.mac_image, exp_img);
        check_val("mac_weight", bus.mac_weight, exp_wgt);
        check_val("mac_exp_bias", bus.mac_exp_bias, exp_eb);
        mac_hist.push_back(mac_fn(exp_img, exp_wgt, exp_eb));
        if (mac_hist.size() > MAC_LAT) bus.mac_out = mac_hist.pop_front();

        exp_ready = in_job && (issued_m < nops_m) && ((issued_m - popped_m) < DEPTH);
        exp_valid = (q.size() > 0) && (q[0].t <= cyc);
        check_val("src_ready", bus.src_ready, exp_ready);
        check_val("busy", bus.busy, in_job);
        check_val("done", bus.done, done_tmr == 1);
        check_val("res_valid", bus.res_valid, exp_valid);
        if (exp_valid) begin
            check_val("res_data", bus.res_data, q[0].data);
            check_val("res_last", bus.res_last, q[0].last);
        end

        bus.res_ready = ($urandom_range(99) < p_ready);
        if (exp_valid && bus.res_ready) begin
            void'(q.pop_front());
            popped_m++;
            if (popped_m == nops_m) done_tmr = 3;
        end

        bus.start   = start_req;
        bus.num_ops = 16'(start_n);
        if (start_req && !in_job && done_tmr == 0) begin
            if (start_n != 0) begin
                in_job   = 1;
                nops_m   = start_n;
                issued_m = 0;
                popped_m = 0;
            end else begin
                done_tmr = 2;
            end
        end

        rnd = {$urandom(), $urandom(), $urandom()};
        bus.src_image    = rnd[71:0];
        rnd = {$urandom(), $urandom(), $urandom()};
        bus.src_weight   = rnd[35:0];
        bus.src_exp_bias = rnd[68:64];
        bus.src_valid    = ($urandom_range(99) < p_valid);
        if (bus.src_valid && bus.src_ready) hs_seen++;
        hs = bus.src_valid && exp_ready;
        if (hs) begin
            exp_img = bus.src_image;
            exp_wgt = bus.src_weight;
            exp_eb  = bus.src_exp_bias;
            q.push_back('{data: mac_fn(exp_img, exp_wgt, exp_eb),
                          last: (issued_m == nops_m - 1), t: cyc + MAC_LAT + 2});
            issued_m++;
        end else begin
            exp_img = '0;
            exp_wgt = '0;
            exp_eb  = '0;
        end
    endtask

    task automatic start_job(input int n);
        start_req = 1;
        start_n   = n;
        step();
        start_req = 0;
    endtask

    task automatic run_job();
        int guard = 0;
        while ((in_job || done_tmr != 0) && guard < LIMIT) begin
            step();
            guard++;
        end
        if (guard >= LIMIT) check_val("job_timeout", 1'b1, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_busy"}, bus.busy, 1'b0);
        check_val({tag, "_done"}, bus.done, 1'b0);
        check_val({tag, "_src_ready"}, bus.src_ready, 1'b0);
        check_val({tag, "_res_valid"}, bus.res_valid, 1'b0);
        check_val({tag, "_res_last"}, bus.res_last, 1'b0);
        check_val({tag, "_res_data"}, bus.res_data, 16'h0);
        check_val({tag, "_mac_image"}, bus.mac_image, 72'h0);
        check_val({tag, "_mac_weight"}, bus.mac_weight, 36'h0);
        check_val({tag, "_mac_exp_bias"}, bus.mac_exp_bias, 5'h0);
    endtask

    // Asserted mid-cycle so the asynchronous clear is observable before the next edge.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1 check_reset_outputs("mid_reset");
        q.delete();
        in_job = 0; done_tmr = 0;
        issued_m = 0; popped_m = 0; nops_m = 0;
        exp_img = '0; exp_wgt = '0; exp_eb = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        bus.start = 0; bus.num_ops = '0; bus.src_valid = 0;
        bus.src_image = '0; bus.src_weight = '0; bus.src_exp_bias = '0;
        bus.mac_out = '0; bus.res_ready = 0;
        #1 check_reset_outputs("por");
        step();
        step();
        rst = 1'b0;

        // Single beat
        p_valid = 100; p_ready = 100;
        start_job(1);
        run_job();
        repeat (2) step();

        // Streaming at full rate
        start_job(20);
        run_job();
        repeat (2) step();

        // Consumer backpressure limits issue to the credit count
        p_ready = 0; hs_seen = 0;
        start_job(12);
        repeat (25) step();
        check_val("bp_issued", hs_seen, 8);
        p_ready = 100;
        run_job();

        // Zero-length job
        hs_seen = 0; p_valid = 60;
        start_job(0);
        run_job();
        check_val("zero_issue", hs_seen, 0);

        // start during RUN must not disturb the job
        p_valid = 100; p_ready = 100;
        start_job(6);
        repeat (3) step();
        start_job(3);
        run_job();
        repeat (2) step();

        // Reset with beats split between tracker and FIFO
        p_ready = 0;
        start_job(5);
        repeat (9) step();
        check_val("pre_reset_valid", bus.res_valid, 1'b1);
        do_reset();
        repeat (10) step();
        p_ready = 100;
        start_job(4);
        run_job();

        // Random toggling on both sides
        for (int j = 0; j < 4; j++) begin
            p_valid = 40 + 20 * j;
            p_ready = 70 - 15 * j;
            start_job(int'($urandom_range(40, 10)));
            run_job();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
